sram_rw_arbiter: RTL

Controller for one single-port 8192x64 SRAM macro (one shared RW port, read data one cycle after a read command, no write mask). On reset it zero-fills the whole array. After that it shares the port between one write requester and one read requester, with a bounded-starvation priority rule. Placed between the requesting pipeline stages and the macro's RW0 pins.

---
 rtl/sram_rw_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: owns the RW port of one single-port SRAM macro.
// Out of reset it zero-fills the array, then shares the port between one
// writer and one reader. Writes win by default, but a waiting read gets
// the port after STARVE_LIMIT consecutive write grants.
module sram_rw_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [3:0]        starve_cnt;
  logic              read_prio;
  logic              w_grant, r_grant;

  // Next state, handshakes and macro command; all idle while reset is held
  always_comb begin
    state_nxt  = state;
    init_done  = 1'b0;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    w_grant    = 1'b0;
    r_grant    = 1'b0;
    read_prio  = (starve_cnt == LIMIT);
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_cnt;
          if (init_cnt == LAST_ADDR) state_nxt = RUN;
        end
        RUN: begin
          init_done = 1'b1;
          // Readies look only at the other side's valid, so grants are exclusive
          w_ready   = !r_valid || !read_prio;
          r_ready   = !w_valid || read_prio;
          w_grant   = w_valid && w_ready;
          r_grant   = r_valid && r_ready;
          if (w_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wdata = w_data;
          end else if (r_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = r_addr;
            sram_wdata = w_data;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // State register and zero-fill sweep address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Count write grants that bypassed a waiting read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == RUN) begin
      if (r_grant || !r_valid) starve_cnt <= '0;
      else if (w_grant)        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Macro returns read data one cycle after the command
  always_ff @(posedge clock or posedge reset) begin
    if (reset) resp_valid <= 1'b0;
    else       resp_valid <= r_grant;
  end

  assign resp_data = sram_rdata;

endmodule
